// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-multiplexes a double-buffered
// hex value onto one decoder with optional leading-zero blanking.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    blank_lz,
  output logic [3:0]              digit_out,
  output logic                    digit_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start,
  output logic                    update_pending
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]             cnt_r;
  logic [IW-1:0]             idx_r;
  logic [4*NUM_DIGITS-1:0]   pend_r;
  logic [4*NUM_DIGITS-1:0]   disp_r;
  logic                      pend_flag_r;
  logic                      frame_start_r;

  logic                      tick_s;
  logic                      wrap_s;
  logic [NUM_DIGITS-1:0]     zero_above_s;
  logic                      zero_acc_s;
  logic                      dark_s;
  logic [3:0]                nib_s;

  assign tick_s = (cnt_r == CW'(DIV - 1));
  assign wrap_s = tick_s && (idx_r == IW'(NUM_DIGITS - 1));

  // Scan timing plus shadow/display buffering; a new value only lands on a frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= {CW{1'b0}};
      idx_r         <= {IW{1'b0}};
      pend_r        <= {(4*NUM_DIGITS){1'b0}};
      disp_r        <= {(4*NUM_DIGITS){1'b0}};
      pend_flag_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      if (tick_s) begin
        cnt_r <= {CW{1'b0}};
        idx_r <= wrap_s ? {IW{1'b0}} : idx_r + IW'(1);
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      frame_start_r <= wrap_s;
      if (load && wrap_s) begin
        disp_r      <= value_in;
        pend_flag_r <= 1'b0;
      end else if (load) begin
        pend_r      <= value_in;
        pend_flag_r <= 1'b1;
      end else if (wrap_s && pend_flag_r) begin
        disp_r      <= pend_r;
        pend_flag_r <= 1'b0;
      end
    end
  end

  // zero_above_s[i] is set when nibbles i..NUM_DIGITS-1 of the display are all zero
  always_comb begin
    zero_above_s = {NUM_DIGITS{1'b0}};
    zero_acc_s   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc_s      = zero_acc_s & (disp_r[4*i +: 4] == 4'h0);
      zero_above_s[i] = zero_acc_s;
    end
  end

  assign nib_s  = 4'(disp_r >> {idx_r, 2'b00});
  assign dark_s = blank_lz && (idx_r != {IW{1'b0}}) && zero_above_s[idx_r];

  // Decoder drive; a dark digit keeps its select so scan timing never changes
  always_comb begin
    if (dark_s) begin
      digit_out = 4'h0;
      digit_en  = 1'b0;
    end else begin
      digit_out = nib_s;
      digit_en  = 1'b1;
    end
  end

  assign digit_sel      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;
  assign frame_start    = frame_start_r;
  assign update_pending = pend_flag_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (NUM_DIGITS=4, DIV=4): a per-cycle vector
// table from reset release, then a mid-frame reset sequence.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic        digit_en;
  logic [3:0]  digit_sel;
  logic        frame_start;
  logic        update_pending;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        bl;
    logic [3:0]  sel;
    logic [3:0]  out;
    logic        en;
    logic        fs;
    logic        up;
  } vec_t;

  vec_t vecs[$];

  ssd_scan_ctrl #(.NUM_DIGITS(4), .DIV(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .value_in       (value_in),
    .blank_lz       (blank_lz),
    .digit_out      (digit_out),
    .digit_en       (digit_en),
    .digit_sel      (digit_sel),
    .frame_start    (frame_start),
    .update_pending (update_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic seg(input int n, input logic ld, input logic [15:0] val, input logic bl,
                     input logic [3:0] sel, input logic [3:0] out, input logic en,
                     input logic fs, input logic up);
    vec_t v;
    v.ld = ld; v.val = val; v.bl = bl; v.sel = sel; v.out = out; v.en = en; v.fs = fs; v.up = up;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] sel, input logic [3:0] out,
                       input logic en, input logic fs, input logic up);
    tests_run++;
    if ({digit_sel, digit_out, digit_en, frame_start, update_pending} !== {sel, out, en, fs, up}) begin
      tests_failed++;
      $display("FAIL %s: got sel=%b out=%h en=%b fs=%b up=%b, expected sel=%b out=%h en=%b fs=%b up=%b",
               name, digit_sel, digit_out, digit_en, frame_start, update_pending,
               sel, out, en, fs, up);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] val, input logic bl);
    load = ld; value_in = val; blank_lz = bl;
    @(posedge clk); #1;
  endtask

  initial begin
    load = 1'b0; value_in = 16'h0000; blank_lz = 1'b0; rst_n = 1'b1;

    // Free scan, then mid-frame load of 12A4 during digit 1
    seg(4,1'b0,16'h0,1'b0,4'b0001,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b0,4'b0010,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b0,4'b0100,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b0,4'b1000,4'h0,1'b1,1'b0,1'b0);
    seg(1,1'b0,16'h0,1'b0,4'b0001,4'h0,1'b1,1'b1,1'b0);
    seg(3,1'b0,16'h0,1'b0,4'b0001,4'h0,1'b1,1'b0,1'b0);
    seg(1,1'b0,16'h0,1'b0,4'b0010,4'h0,1'b1,1'b0,1'b0);
    seg(1,1'b1,16'h12A4,1'b0,4'b0010,4'h0,1'b1,1'b0,1'b0);
    seg(2,1'b0,16'h0,1'b0,4'b0010,4'h0,1'b1,1'b0,1'b1);
    seg(4,1'b0,16'h0,1'b0,4'b0100,4'h0,1'b1,1'b0,1'b1);
    seg(4,1'b0,16'h0,1'b0,4'b1000,4'h0,1'b1,1'b0,1'b1);
    // 12A4 shown; overwrite with 1111 then 2222
    seg(1,1'b0,16'h0,1'b0,4'b0001,4'h4,1'b1,1'b1,1'b0);
    seg(1,1'b0,16'h0,1'b0,4'b0001,4'h4,1'b1,1'b0,1'b0);
    seg(1,1'b1,16'h1111,1'b0,4'b0001,4'h4,1'b1,1'b0,1'b0);
    seg(1,1'b0,16'h0,1'b0,4'b0001,4'h4,1'b1,1'b0,1'b1);
    seg(4,1'b0,16'h0,1'b0,4'b0010,4'hA,1'b1,1'b0,1'b1);
    seg(1,1'b1,16'h2222,1'b0,4'b0100,4'h2,1'b1,1'b0,1'b1);
    seg(3,1'b0,16'h0,1'b0,4'b0100,4'h2,1'b1,1'b0,1'b1);
    seg(4,1'b0,16'h0,1'b0,4'b1000,4'h1,1'b1,1'b0,1'b1);
    // 2222 shown; load 3333 on the wrap cycle
    seg(1,1'b0,16'h0,1'b0,4'b0001,4'h2,1'b1,1'b1,1'b0);
    seg(3,1'b0,16'h0,1'b0,4'b0001,4'h2,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b0,4'b0010,4'h2,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b0,4'b0100,4'h2,1'b1,1'b0,1'b0);
    seg(3,1'b0,16'h0,1'b0,4'b1000,4'h2,1'b1,1'b0,1'b0);
    seg(1,1'b1,16'h3333,1'b0,4'b1000,4'h2,1'b1,1'b0,1'b0);
    // 3333 shown; load 0050 mid-frame
    seg(1,1'b0,16'h0,1'b0,4'b0001,4'h3,1'b1,1'b1,1'b0);
    seg(3,1'b0,16'h0,1'b0,4'b0001,4'h3,1'b1,1'b0,1'b0);
    seg(2,1'b0,16'h0,1'b0,4'b0010,4'h3,1'b1,1'b0,1'b0);
    seg(1,1'b1,16'h0050,1'b0,4'b0010,4'h3,1'b1,1'b0,1'b0);
    seg(1,1'b0,16'h0,1'b0,4'b0010,4'h3,1'b1,1'b0,1'b1);
    seg(4,1'b0,16'h0,1'b0,4'b0100,4'h3,1'b1,1'b0,1'b1);
    seg(4,1'b0,16'h0,1'b0,4'b1000,4'h3,1'b1,1'b0,1'b1);
    // 0050 with blanking; coincident load of 0000
    seg(1,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b1,1'b0);
    seg(3,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b1,4'b0010,4'h5,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b1,4'b0100,4'h0,1'b0,1'b0,1'b0);
    seg(3,1'b0,16'h0,1'b1,4'b1000,4'h0,1'b0,1'b0,1'b0);
    seg(1,1'b1,16'h0000,1'b1,4'b1000,4'h0,1'b0,1'b0,1'b0);
    // 0000 with blanking, blank_lz dropped at digit 2; coincident load of 5000
    seg(1,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b1,1'b0);
    seg(3,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b1,4'b0010,4'h0,1'b0,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b0,4'b0100,4'h0,1'b1,1'b0,1'b0);
    seg(3,1'b0,16'h0,1'b0,4'b1000,4'h0,1'b1,1'b0,1'b0);
    seg(1,1'b1,16'h5000,1'b0,4'b1000,4'h0,1'b1,1'b0,1'b0);
    // 5000 with blanking: inner zeros stay lit because a higher digit is non-zero
    seg(1,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b1,1'b0);
    seg(3,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b1,4'b0010,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b1,4'b0100,4'h0,1'b1,1'b0,1'b0);
    seg(4,1'b0,16'h0,1'b1,4'b1000,4'h5,1'b1,1'b0,1'b0);
    seg(1,1'b0,16'h0,1'b1,4'b0001,4'h0,1'b1,1'b1,1'b0);

    // Asynchronous reset with no clock edge in between
    #1 rst_n = 1'b0;
    #1 check("reset_async", 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hold", 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      load = vecs[r].ld; value_in = vecs[r].val; blank_lz = vecs[r].bl;
      @(negedge clk);
      check($sformatf("vec%0d", r), vecs[r].sel, vecs[r].out, vecs[r].en, vecs[r].fs, vecs[r].up);
      @(posedge clk); #1;
    end

    // Mid-frame reset with an update pending during digit 2
    for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h9999, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1);
    load = 1'b0;
    @(negedge clk);
    check("pre_reset_pending", 4'b0100, 4'h0, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("mid_reset_async", 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    blank_lz = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_c%0d", k), 4'(4'b0001 << ((k / 4) % 4)), 4'h0, 1'b1,
            (k == 16), 1'b0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
